// File: rtl/uart_txfifo_sched.sv
// uart_txfifo_sched: pops the show-ahead TX FIFO, hands bytes to the UART core,
// inserts an inter-frame gap, supports flush and a low-watermark interrupt.
module uart_txfifo_sched #(
    parameter int BW      = 8,
    parameter int BW_ADDR = 7,
    parameter int GAP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic [GAP_W-1:0]   gap_cycles,
    input  logic [BW_ADDR:0]   thr,
    input  logic [BW-1:0]      fifo_dout,
    input  logic               fifo_empty,
    input  logic [BW_ADDR:0]   fifo_rd_count,
    output logic               fifo_rd_en,
    output logic [BW-1:0]      tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               flush_done,
    output logic               irq_thr,
    output logic [15:0]        frames_sent
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, FLUSH_WAIT, FLUSH_RD} state_t;
    state_t             state_q, state_d;
    logic [BW-1:0]      tx_data_q, tx_data_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        frames_q, frames_d;
    logic               flush_pend_q, flush_pend_d;
    logic               irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            gap_q        <= '0;
            frames_q     <= '0;
            flush_pend_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            gap_q        <= gap_d;
            frames_q     <= frames_d;
            flush_pend_q <= flush_pend_d;
            irq_q        <= fifo_rd_count <= thr;
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        gap_d        = gap_q;
        frames_d     = frames_q;
        flush_pend_d = flush_pend_q | (flush && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d      = FLUSH_WAIT;
                    flush_pend_d = 1'b0;
                end else if (en && !fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_data_d = fifo_dout;
                state_d   = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    frames_d = frames_q + 16'd1;
                    if (flush_pend_q || gap_cycles == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = gap_cycles;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gap_d   = gap_q - GAP_W'(1);
                state_d = (gap_q == GAP_W'(1)) ? IDLE : GAP;
            end
            // empty lags a pop by one cycle, so every pop is followed by a re-check
            FLUSH_WAIT: state_d = fifo_empty ? IDLE : FLUSH_RD;
            FLUSH_RD:   state_d = FLUSH_WAIT;
            default:    state_d = IDLE;
        endcase
    end

    assign fifo_rd_en  = state_q == LOAD || state_q == FLUSH_RD;
    assign tx_valid    = state_q == SEND;
    assign tx_data     = tx_data_q;
    assign busy        = state_q != IDLE;
    assign flush_done  = state_q == FLUSH_WAIT && fifo_empty;
    assign irq_thr     = irq_q;
    assign frames_sent = frames_q;
endmodule

// File: tb/tb_uart_txfifo_sched.sv
// tb_uart_txfifo_sched: directed test of the TX FIFO read sequencer against a
// behavioural show-ahead FIFO whose empty flag registers after each pop.
module tb_uart_txfifo_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  gap_cycles = 8'd0;
    logic [7:0]  thr = 8'd2;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rd_count = 8'd0;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        flush_done;
    logic        irq_thr;
    logic [15:0] frames_sent;

    uart_txfifo_sched #(.BW(8), .BW_ADDR(7), .GAP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .gap_cycles(gap_cycles),
        .thr(thr), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .flush_done(flush_done),
        .irq_thr(irq_thr), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    logic [7:0] fq[$];
    logic       push_v = 1'b0;
    logic [7:0] push_d = 8'h00;
    int         pop_err = 0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty || fq.size() == 0) pop_err++;
            else void'(fq.pop_front());
        end
        if (push_v) fq.push_back(push_d);
        fifo_empty    <= (fq.size() == 0);
        fifo_rd_count <= 8'(fq.size());
        fifo_dout     <= (fq.size() != 0) ? fq[0] : 8'h00;
    end

    int         cyc = 0;
    int         hs_n = 0;
    int         hs_t[64];
    logic [7:0] hs_d[64];
    int         rd_cnt = 0;
    int         b2b = 0;
    logic       prev_rd = 1'b0;
    int         fd_cnt = 0;
    int         fd_t = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && tx_valid && tx_ready && hs_n < 64) begin
            hs_t[hs_n] = cyc;
            hs_d[hs_n] = tx_data;
            hs_n++;
        end
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && prev_rd) b2b++;
        prev_rd = fifo_rd_en;
        if (flush_done) begin
            fd_cnt++;
            fd_t = cyc;
        end
    end

    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        push_d = b;
        push_v = 1'b1;
        @(negedge clk);
        push_v = 1'b0;
    endtask

    initial begin
        int h0, rd0, fd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_data", tx_data, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_irq", irq_thr, 0);
        check("rst_fd", flush_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte
        push(8'hA5);
        en = 1'b1;
        for (int i = 0; i < 20 && !fifo_rd_en; i++) @(negedge clk);
        check("t1_rd_en", fifo_rd_en, 1);
        check("t1_valid_lo", tx_valid, 0);
        @(negedge clk);
        check("t1_valid", tx_valid, 1);
        check("t1_data", tx_data, 8'hA5);
        check("t1_rd_off", fifo_rd_en, 0);
        @(negedge clk);
        check("t1_frames", frames_sent, 1);
        check("t1_busy", busy, 0);
        check("t1_valid_off", tx_valid, 0);
        en = 1'b0;

        // gap timing
        h0 = hs_n;
        push(8'h11); push(8'h22); push(8'h33);
        gap_cycles = 8'd4;
        en = 1'b1;
        for (int i = 0; i < 100 && frames_sent != 16'd4; i++) @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
        check("t2_frames", frames_sent, 4);
        check("t2_hs_n", hs_n - h0, 3);
        check("t2_gap_a", hs_t[h0+1] - hs_t[h0], 7);
        check("t2_gap_b", hs_t[h0+2] - hs_t[h0+1], 7);
        check("t2_d0", hs_d[h0], 8'h11);
        check("t2_d2", hs_d[h0+2], 8'h33);
        check("t2_busy", busy, 0);

        // back-to-back with zero gap
        h0 = hs_n;
        gap_cycles = 8'd0;
        push(8'h66); push(8'h99);
        en = 1'b1;
        for (int i = 0; i < 50 && frames_sent != 16'd6; i++) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_b2b_gap", hs_t[h0+1] - hs_t[h0], 3);
        check("t3_d1", hs_d[h0+1], 8'h99);

        // backpressure
        h0 = hs_n;
        tx_ready = 1'b0;
        push(8'h5A);
        en = 1'b1;
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", tx_valid, 1);
            check("t4_hold_data", tx_data, 8'h5A);
            @(negedge clk);
        end
        check("t4_frames_held", frames_sent, 6);
        tx_ready = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("t4_frames", frames_sent, 7);
        check("t4_hs_n", hs_n - h0, 1);
        check("t4_valid_off", tx_valid, 0);

        // flush while idle, with threshold interrupt
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
        repeat (2) @(negedge clk);
        check("t5_count4", fifo_rd_count, 4);
        check("t5_irq_hi_cnt", irq_thr, 0);
        rd0 = rd_cnt;
        fd0 = fd_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 20 && fifo_rd_count != 8'd2; i++) @(negedge clk);
        check("t5_count2", fifo_rd_count, 2);
        check("t5_irq_lag", irq_thr, 0);
        @(negedge clk);
        check("t5_irq_set", irq_thr, 1);
        for (int i = 0; i < 30 && fd_cnt == fd0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t5_pops", rd_cnt - rd0, 4);
        check("t5_fd", fd_cnt - fd0, 1);
        check("t5_empty", fifo_empty, 1);
        check("t5_frames", frames_sent, 7);
        check("t5_busy", busy, 0);

        // flush during SEND
        h0 = hs_n;
        rd0 = rd_cnt;
        fd0 = fd_cnt;
        tx_ready = 1'b0;
        gap_cycles = 8'd3;
        for (int b = 1; b <= 5; b++) push(8'(b));
        en = 1'b1;
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && fd_cnt == fd0; i++) @(negedge clk);
        check("t6_fd", fd_cnt - fd0, 1);
        check("t6_frames", frames_sent, 8);
        check("t6_hs_n", hs_n - h0, 1);
        check("t6_data", hs_d[h0], 8'h01);
        check("t6_no_gap", fd_t - hs_t[h0], 10);
        check("t6_pops", rd_cnt - rd0, 5);
        check("t6_empty", fifo_empty, 1);
        check("t6_busy", busy, 0);
        en = 1'b0;

        // reset mid-SEND
        h0 = hs_n;
        gap_cycles = 8'd0;
        tx_ready = 1'b0;
        push(8'h77);
        en = 1'b1;
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        check("t7_in_send", tx_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_valid", tx_valid, 0);
        check("t7_rd_en", fifo_rd_en, 0);
        check("t7_busy", busy, 0);
        check("t7_data", tx_data, 0);
        check("t7_frames", frames_sent, 0);
        check("t7_irq", irq_thr, 0);
        check("t7_fd", flush_done, 0);
        check("t7_hs_n", hs_n - h0, 0);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("pop_empty", pop_err, 0);
        check("b2b_pops", b2b, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_txfifo_sched.md
Name: uart_txfifo_sched

Overview:
Read-side sequencer for the UART transmit FIFO. It runs entirely in the FIFO read-clock domain.
- Pops bytes from the show-ahead FIFO output (dout is valid while empty=0; rd_en advances it).
- Hands each byte to the UART TX core over a valid/ready handshake.
- Inserts a programmable inter-frame gap.
- Supports a software flush and raises a low-watermark refill interrupt.

Parameters:
BW, 8, FIFO data width and tx_data width
BW_ADDR, 7, FIFO address width; count ports are BW_ADDR+1 bits
GAP_W, 8, width of gap_cycles

Ports:
clk  in  1  clock (FIFO rd_clk domain)
rst_n  in  1  reset
en  in  1  transmit enable (level)
flush  in  1  flush request (1-cycle pulse)
gap_cycles  in  GAP_W  idle cycles inserted after each frame
thr  in  BW_ADDR+1  low-watermark threshold
fifo_dout  in  BW  FIFO head data (show-ahead)
fifo_empty  in  1  FIFO empty; updates 1 cycle after a pop
fifo_rd_count  in  BW_ADDR+1  FIFO read-side occupancy
fifo_rd_en  out  1  FIFO pop strobe
tx_data  out  BW  byte to UART TX core
tx_valid  out  1  tx_data valid
tx_ready  in  1  TX core accepts
busy  out  1  state != IDLE
flush_done  out  1  1-cycle pulse when flush completes
irq_thr  out  1  fifo_rd_count <= thr (registered level)
frames_sent  out  16  handshake counter, wraps

Interface note: one clock, clk; reset rst_n is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; fifo_rd_en=0; tx_valid=0; tx_data=0; flush_done=0; irq_thr=0; frames_sent=0; flush_pend=0; gap counter=0.
  - Reset mid-frame drops tx_valid on the next cycle with no handshake counted.
- Outputs:
  - fifo_rd_en is a Moore output, high only in LOAD or FLUSH_RD.
  - tx_valid is high only in SEND.
- IDLE:
  - flush or flush_pend -> FLUSH_WAIT; clear flush_pend.
  - Else en=1 and fifo_empty=0 -> LOAD.
  - flush has priority over a transmit start in the same cycle.
- LOAD (1 cycle): fifo_rd_en=1; tx_data <= fifo_dout at the end of the cycle; -> SEND.
- SEND:
  - tx_valid=1; tx_data stable until tx_ready=1.
  - On handshake: frames_sent+1, mod 2^16.
  - Then: flush_pend=1 -> IDLE (gap skipped); gap_cycles=0 -> IDLE; else load gap counter with gap_cycles -> GAP.
- GAP:
  - Exactly gap_cycles cycles; the counter decrements and reaching 1 -> IDLE.
  - gap_cycles is sampled only at the handshake.
- Back-to-back with gap 0:
  - Handshake cycle t -> IDLE t+1 -> LOAD t+2 -> SEND t+3.
  - Minimum 3 cycles per byte with tx_ready tied high.
  - SEND occupancy guarantees fifo_empty has settled after the previous pop before IDLE samples it.
- Flush:
  - A flush pulse outside IDLE sets flush_pend, which is served when IDLE is next entered.
  - A frame in SEND always completes; a frame in GAP aborts the gap only via the rule above, otherwise GAP finishes normally.
  - FLUSH_WAIT (fifo_rd_en=0): fifo_empty=1 -> pulse flush_done, -> IDLE; else -> FLUSH_RD.
  - FLUSH_RD: fifo_rd_en=1 for 1 cycle -> FLUSH_WAIT.
  - Pops alternate with wait cycles because the FIFO empty flag lags the pop by 1 cycle; this never over-reads.
  - en is ignored during flush.
- en deasserted mid-frame: the current SEND/GAP completes, then the block stays in IDLE.
- irq_thr: registered each cycle from (fifo_rd_count <= thr), unsigned compare; thr=0 asserts only when the FIFO is empty.
- fifo_rd_en is never asserted while fifo_empty=1 is sampled in the deciding state. Popping an empty FIFO is a verification error.

Test Plan:
- Single byte: FIFO holds 0xA5, en=1, gap=0, tx_ready=1 -> fifo_rd_en for 1 cycle, tx_valid 1 cycle later with tx_data=0xA5, frames_sent=1, back to IDLE, busy=0.
- Gap timing: 3 bytes, gap_cycles=4, tx_ready=1 -> handshakes exactly 7 cycles apart; frames_sent=3; no pop while empty.
- Backpressure: tx_ready=0 for 5 cycles after tx_valid rises -> tx_valid and tx_data held 5 cycles, one handshake, frames_sent+1 only.
- Flush idle: 4 bytes queued, en=0, flush pulse -> 4 fifo_rd_en pulses on alternating cycles, fifo_empty=1, flush_done pulses once, frames_sent unchanged.
- Flush during SEND: 5 bytes queued, flush while tx_ready=0 -> current byte completes (frames_sent+1), no gap, remaining 4 flushed, flush_done=1.
- Reset/threshold: thr=2, count falls 4->2 -> irq_thr=1 one cycle after count=2. rst_n=0 mid-SEND -> all outputs at reset values next cycle; frames_sent=0.
